// File: rtl/monster_sequencer.sv
// Monster spawn/approach game-state sequencer for the four tunnel lanes.
// Drives lane occupancy, distance, broken-cannon flags, score and game state to the renderer.
module monster_sequencer #(
    parameter int unsigned SPAWN_GAP  = 96,
    parameter int unsigned STEP_DIV   = 4,
    parameter int unsigned START_DIST = 200,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  hit,
    output logic [3:0]  monster,
    output logic [31:0] monster_dist,
    output logic [3:0]  broken,
    output logic [7:0]  score,
    output logic [1:0]  state
);

    localparam int unsigned TW = $clog2(SPAWN_GAP);
    localparam int unsigned PW = $clog2(STEP_DIV);
    localparam logic [TW-1:0] GAP_LAST  = TW'(SPAWN_GAP - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [7:0]    DIST_INIT = 8'(START_DIST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      mon_q, mon_d;
    logic [3:0]      brk_q, brk_d;
    logic [3:0][7:0] dist_q, dist_d;
    logic [7:0]      score_q, score_d;

    logic            attempt_s;
    logic            strobe_s;
    logic            spawn_s;
    logic [3:0]      hits_s;
    logic [2:0]      pick_s;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {6'd0, n};
        if (s[8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    // Returns {found, lane}: first free lane probing base, base+1, base+2, base+3.
    function automatic logic [2:0] pick_lane(input logic [3:0] free, input logic [1:0] base);
        logic [2:0] r;
        logic [1:0] ln;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            ln = base + 2'(k);
            if (free[ln]) begin
                r = {1'b1, ln};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next-state logic: timers, lane updates, spawn and game-state transitions.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_next(lfsr_q);
        timer_d   = timer_q;
        presc_d   = presc_q;
        mon_d     = mon_q;
        brk_d     = brk_q;
        dist_d    = dist_q;
        score_d   = score_q;
        attempt_s = 1'b0;
        strobe_s  = 1'b0;
        spawn_s   = 1'b0;
        hits_s    = 4'b0000;
        pick_s    = 3'b000;
        case (state_q)
            ST_PLAY: begin
                attempt_s = (timer_q == {TW{1'b0}});
                strobe_s  = (presc_q == PRE_LAST);
                timer_d   = attempt_s ? GAP_LAST : (timer_q - TW'(1));
                presc_d   = strobe_s ? {PW{1'b0}} : (presc_q + PW'(1));
                hits_s    = hit & mon_q;
                score_d   = sat_add(score_q, popcount4(hits_s));
                // Qualification uses registered flags, so lanes freed this cycle wait for the next attempt.
                pick_s    = pick_lane(~(mon_q | brk_q), lfsr_q[1:0]);
                spawn_s   = attempt_s & pick_s[2];
                for (int l = 0; l < 4; l++) begin
                    if (hits_s[l]) begin
                        mon_d[l]  = 1'b0;
                        dist_d[l] = 8'd0;
                    end else if (spawn_s && (pick_s[1:0] == 2'(l))) begin
                        mon_d[l]  = 1'b1;
                        dist_d[l] = DIST_INIT;
                    end else if (strobe_s && mon_q[l]) begin
                        if (dist_q[l] > 8'd1) begin
                            dist_d[l] = dist_q[l] - 8'd1;
                        end else begin
                            dist_d[l] = 8'd0;
                            mon_d[l]  = 1'b0;
                            brk_d[l]  = 1'b1;
                        end
                    end else begin
                        mon_d[l]  = mon_q[l];
                        dist_d[l] = dist_q[l];
                    end
                end
                if (brk_d == 4'b1111) begin
                    state_d = ST_OVER;
                    mon_d   = 4'b0000;
                    dist_d  = {4{8'd0}};
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_IDLE, ST_OVER: begin
                if (Start) begin
                    state_d = ST_PLAY;
                    mon_d   = 4'b0000;
                    brk_d   = 4'b0000;
                    dist_d  = {4{8'd0}};
                    score_d = 8'd0;
                    presc_d = {PW{1'b0}};
                    timer_d = GAP_LAST;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            timer_q <= GAP_LAST;
            presc_q <= {PW{1'b0}};
            mon_q   <= 4'b0000;
            brk_q   <= 4'b0000;
            dist_q  <= {4{8'd0}};
            score_q <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
            mon_q   <= mon_d;
            brk_q   <= brk_d;
            dist_q  <= dist_d;
            score_q <= score_d;
        end
    end

    assign monster      = mon_q;
    assign monster_dist = dist_q;
    assign broken       = brk_q;
    assign score        = score_q;
    assign state        = state_q;

endmodule

// File: tb/tb_monster_sequencer.sv
// Bench for monster_sequencer: scripted table, hand sequences and random play against a lane-level model.
module tb_monster_sequencer;

    localparam int GAP  = 4;
    localparam int STEP = 2;
    localparam int DIST = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [3:0]  hit;
    logic [3:0]  monster;
    logic [31:0] monster_dist;
    logic [3:0]  broken;
    logic [7:0]  score;
    logic [1:0]  state;

    int checks;
    int errors;

    monster_sequencer #(
        .SPAWN_GAP(GAP), .STEP_DIV(STEP), .START_DIST(DIST), .LFSR_SEED(SEED)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .hit(hit),
        .monster(monster), .monster_dist(monster_dist), .broken(broken),
        .score(score), .state(state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: per-lane arrays, cycles counted since PLAY entry.
    int          m_state;
    logic [15:0] m_lfsr;
    int          m_n;
    bit          m_mon[4];
    bit          m_brk[4];
    int          m_dist[4];
    int          m_score;

    task automatic model_reset();
        m_state = 0;
        m_lfsr  = SEED;
        m_n     = 0;
        m_score = 0;
        for (int l = 0; l < 4; l++) begin
            m_mon[l] = 0; m_brk[l] = 0; m_dist[l] = 0;
        end
    endtask

    task automatic model_step(input logic s, input logic [3:0] h);
        logic [15:0] pre;
        bit omon[4];
        bit obrk[4];
        int base;
        int nbrk;
        pre    = m_lfsr;
        m_lfsr = {pre[14:0], pre[15] ^ pre[13] ^ pre[12] ^ pre[10]};
        if (m_state == 1) begin
            m_n = m_n + 1;
            for (int l = 0; l < 4; l++) begin
                omon[l] = m_mon[l]; obrk[l] = m_brk[l];
            end
            for (int l = 0; l < 4; l++) begin
                if (h[l] && omon[l]) begin
                    m_mon[l] = 0; m_dist[l] = 0;
                    if (m_score < 255) m_score = m_score + 1;
                end else if ((m_n % STEP) == 0 && omon[l]) begin
                    if (m_dist[l] > 1) m_dist[l] = m_dist[l] - 1;
                    else begin
                        m_dist[l] = 0; m_mon[l] = 0; m_brk[l] = 1;
                    end
                end
            end
            if ((m_n % GAP) == 0) begin
                base = int'(pre[1:0]);
                for (int k = 0; k < 4; k++) begin
                    if (!omon[(base + k) % 4] && !obrk[(base + k) % 4]) begin
                        m_mon[(base + k) % 4]  = 1;
                        m_dist[(base + k) % 4] = DIST;
                        break;
                    end
                end
            end
            nbrk = 0;
            for (int l = 0; l < 4; l++) nbrk += int'(m_brk[l]);
            if (nbrk == 4) begin
                m_state = 2;
                for (int l = 0; l < 4; l++) begin
                    m_mon[l] = 0; m_dist[l] = 0;
                end
            end
        end else if (s) begin
            m_state = 1;
            m_n     = 0;
            m_score = 0;
            for (int l = 0; l < 4; l++) begin
                m_mon[l] = 0; m_brk[l] = 0; m_dist[l] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0]  em;
        logic [3:0]  eb;
        logic [31:0] ed;
        for (int l = 0; l < 4; l++) begin
            em[l] = m_mon[l];
            eb[l] = m_brk[l];
            ed[8*l +: 8] = 8'(m_dist[l]);
        end
        chk("model_state", 32'(state), 32'(m_state));
        chk("model_monster", 32'(monster), 32'(em));
        chk("model_dist", monster_dist, ed);
        chk("model_broken", 32'(broken), 32'(eb));
        chk("model_score", 32'(score), 32'(m_score));
    endtask

    // Inputs are applied 1 time unit after a rising edge and outputs sampled 1 unit after the next.
    task automatic tick(input logic s, input logic [3:0] h);
        Start = s;
        hit   = h;
        @(posedge Clk);
        model_step(s, h);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        Reset = 1'b0;
        Start = 1'b0;
        hit   = 4'h0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_monster", 32'(monster), 32'd0);
        chk("rst_broken", 32'(broken), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_dist", monster_dist, 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    typedef struct {
        logic       start;
        logic [3:0] hitv;
        int         reps;
        logic [1:0] st;
        int         mcnt;
        int         bcnt;
        int         sc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int lane_a;
        int lane_b;
        int lane_e;
        logic [3:0] brk_save;
        logic [3:0] hv;

        checks = 0;
        errors = 0;
        tbl[0]  = '{1'b0, 4'h0, 3, 2'd0, 0, 0, 0};
        tbl[1]  = '{1'b1, 4'h0, 1, 2'd1, 0, 0, 0};
        tbl[2]  = '{1'b0, 4'h0, 3, 2'd1, 0, 0, 0};
        tbl[3]  = '{1'b0, 4'h0, 4, 2'd1, 1, 0, 0};
        tbl[4]  = '{1'b0, 4'h0, 1, 2'd1, 2, 0, 0};
        tbl[5]  = '{1'b0, 4'hF, 1, 2'd1, 0, 0, 2};
        tbl[6]  = '{1'b0, 4'h0, 2, 2'd1, 0, 0, 2};
        tbl[7]  = '{1'b0, 4'h0, 4, 2'd1, 1, 0, 2};
        tbl[8]  = '{1'b0, 4'h0, 2, 2'd1, 2, 0, 2};
        tbl[9]  = '{1'b0, 4'h0, 2, 2'd1, 1, 1, 2};
        tbl[10] = '{1'b0, 4'h0, 2, 2'd1, 2, 1, 2};
        tbl[11] = '{1'b0, 4'h0, 2, 2'd1, 1, 2, 2};
        tbl[12] = '{1'b0, 4'h0, 2, 2'd1, 2, 2, 2};
        tbl[13] = '{1'b0, 4'h0, 4, 2'd1, 1, 3, 2};
        tbl[14] = '{1'b0, 4'h0, 1, 2'd2, 0, 4, 2};
        tbl[15] = '{1'b0, 4'h0, 3, 2'd2, 0, 4, 2};
        tbl[16] = '{1'b1, 4'h0, 1, 2'd1, 0, 0, 0};

        Reset = 1'b0;
        Start = 1'b0;
        hit   = 4'h0;
        model_reset();
        #2;
        chk("init_state", 32'(state), 32'd0);
        chk("init_monster", 32'(monster), 32'd0);
        chk("init_score", 32'(score), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Idle with Start low: nothing happens.
        for (int i = 0; i < 500; i++) begin
            tick(1'b0, 4'h0);
            if (state != 2'd0 || monster != 4'h0 || score != 8'd0) begin
                chk("idle_quiet", {state, monster, score}, 32'd0);
            end
        end

        // Scripted game: spawns, a double hit, four arrivals, OVER, restart.
        for (int r = 0; r < 17; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                tick(tbl[r].start, tbl[r].hitv);
                chk($sformatf("tbl%0d_state", r), 32'(state), 32'(tbl[r].st));
                chk($sformatf("tbl%0d_mcnt", r), 32'($countones(monster)), 32'(tbl[r].mcnt));
                chk($sformatf("tbl%0d_bcnt", r), 32'($countones(broken)), 32'(tbl[r].bcnt));
                chk($sformatf("tbl%0d_score", r), 32'(score), 32'(tbl[r].sc));
            end
        end

        // Hit vs arrival on the same strobe, hit on an empty lane, hit at dist 2.
        for (int i = 0; i < 8; i++) tick(1'b0, 4'h0);
        lane_a = -1;
        for (int l = 0; l < 4; l++) if (m_mon[l] && m_dist[l] == 1) lane_a = l;
        chk("seq_first_spawn_found", 32'(lane_a >= 0), 32'd1);
        if (lane_a < 0) lane_a = 0;
        tick(1'b0, 4'h0);
        hv = 4'h0;
        hv[lane_a] = 1'b1;
        tick(1'b0, hv);
        chk("hit_vs_arrival_broken", 32'(broken[lane_a]), 32'd0);
        chk("hit_vs_arrival_score", 32'(score), 32'd1);
        lane_e = 0;
        for (int l = 3; l >= 0; l--) if (!m_mon[l]) lane_e = l;
        hv = 4'h0;
        hv[lane_e] = 1'b1;
        tick(1'b0, hv);
        chk("empty_hit_score", 32'(score), 32'd1);
        lane_b = -1;
        for (int l = 0; l < 4; l++) if (m_mon[l] && m_dist[l] == 2) lane_b = l;
        chk("seq_second_dist2", 32'(lane_b >= 0), 32'd1);
        if (lane_b < 0) lane_b = 0;
        brk_save = broken;
        hv = 4'h0;
        hv[lane_b] = 1'b1;
        tick(1'b0, hv);
        chk("hit_d2_monster", 32'(monster[lane_b]), 32'd0);
        chk("hit_d2_score", 32'(score), 32'd2);
        chk("hit_d2_broken", 32'(broken), 32'(brk_save));

        // Random play against the model, with occasional mid-game reset.
        for (int i = 0; i < 4000; i++) begin
            hv = 4'h0;
            for (int l = 0; l < 4; l++) hv[l] = ($urandom_range(0, 5) == 0);
            tick($urandom_range(0, 59) == 0, hv);
            if (i % 1300 == 1299) async_reset();
        end

        // Score saturation: hit every lane every cycle so each spawn scores.
        async_reset();
        tick(1'b1, 4'h0);
        for (int i = 0; i < 1100; i++) tick(1'b0, 4'hF);
        chk("score_saturate", 32'(score), 32'd255);
        chk("saturate_state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/monster_sequencer.md
# monster_sequencer

Game-state stage directly upstream of the playfield renderer. Spawns monsters in the four tunnel lanes (top, bottom, left, right) from a pseudo-random schedule and advances each one toward the ship. It clears monsters on laser hits, marks a lane's cannon broken when a monster arrives, and keeps score and game-over state. Its per-lane presence, distance and broken flags feed the renderer's monster and bullet-blocking logic (`top_monster`, `top_broken`, and so on).

## Interface
Parameters:
- SPAWN_GAP, 96: game-clock cycles between spawn attempts (≥2).
- STEP_DIV, 4: game-clock cycles per one-unit distance step (≥2).
- START_DIST, 200: distance loaded at spawn (1..255).
- LFSR_SEED, 16'hACE1: LFSR reset value (non-zero).

Ports:
- Clk, input, 1: slow game clock, same domain as the renderer's motion logic.
- Reset, input, 1: reset, asynchronous, active-low (0 = reset).
- Start, input, 1: level-sensitive start request, already debounced.
- hit, input, 4: per-lane laser-hit pulse, bit0 = top, bit1 = bottom, bit2 = left, bit3 = right.
- monster, output, 4: lane occupied.
- monster_dist, output, 32: lane n distance is [8n+7:8n].
- broken, output, 4: lane cannon broken.
- score, output, 8: hits, saturating.
- state, output, 2: 0 = IDLE, 1 = PLAY, 2 = OVER.

## Operation
- FSM states:
  - IDLE: nothing moves or spawns. Start=1 goes to PLAY.
  - PLAY: exit to OVER on the cycle the 4th broken bit would become set.
  - OVER: monster cleared, timers frozen. Start=1 goes to PLAY.
- Entry to PLAY clears:
  - monster, broken, score and all dist fields, which become 0.
  - The step prescaler, which becomes 0.
  - The spawn timer, which loads SPAWN_GAP-1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle in every state except reset.
  - Shift-in bit = b15^b13^b12^b10; the register shifts left.
- Spawn timer (PLAY only):
  - Decrements each cycle.
  - At 0 it reloads SPAWN_GAP-1 and makes a spawn attempt.
- Spawn attempt:
  - Candidate lane L = lfsr[1:0], using the pre-shift value in that cycle.
  - Probe order is L, L+1, L+2, L+3 (mod 4).
  - The first lane with monster=0 and broken=0 gets monster=1 and dist=START_DIST.
  - If no lane qualifies, nothing spawns.
  - At most one spawn per attempt.
- Step prescaler (PLAY only):
  - Counts 0..STEP_DIV-1 and wraps.
  - A step strobe occurs on the cycle the count is STEP_DIV-1.
- On a step strobe, each lane with monster=1:
  - dist>1: dist decrements by 1.
  - dist==1: dist=0, monster=0, broken=1 (arrival).
- Hit on lane n (PLAY only):
  - If monster[n]=1: monster[n]=0, dist[n]=0, score+1 saturating at 255.
  - If monster[n]=0: the hit is ignored.
  - Hits on several lanes in one cycle each count.
- Same-cycle priority per lane:
  - Hit beats arrival and step: no broken, score increments.
  - Spawn never targets a lane being hit or arriving that cycle, because qualification uses the pre-update registered flags.
  - A lane freed this cycle is eligible only from the next attempt onward.
- Start held high in PLAY has no effect. Start in OVER re-enters PLAY even if held continuously.
- hit is ignored in IDLE and OVER.

## Timing
- All outputs are registered and change only on Clk rising edge (or asynchronously on reset).
- Reset values:
  - state = IDLE.
  - monster = 0, broken = 0, score = 0, monster_dist = 0.
  - lfsr = LFSR_SEED.
  - Prescaler 0, spawn timer SPAWN_GAP-1.
- Latencies:
  - Start to state=PLAY: 1 cycle.
  - First spawn attempt: SPAWN_GAP cycles after the PLAY-entry edge.
  - Spawn, hit, and arrival effects are visible one cycle after the triggering edge.
- Step strobes fall STEP_DIV, 2·STEP_DIV, … cycles after PLAY entry.
  - A monster spawned at cycle t first decrements on the first strobe after t.
  - A monster arrives after START_DIST strobes.
- OVER: monster and dist are cleared in the same cycle as the transition. broken reads 4'b1111.
- Reset asserted mid-game forces the reset values immediately. Release is synchronised by the top level.

## Test plan
- **Reset/idle:** Reset=0, then release with Start=0 for 500 cycles. Required: state=0, monster=0, score=0 throughout.
- **Spawn and approach** (SPAWN_GAP=4, STEP_DIV=2, START_DIST=3; Start pulse; lfsr[1:0]=L at attempt):
  - One cycle after the first attempt: monster bit L=1, dist=3.
  - dist then reads 2, then 1 on later strobes.
  - On the arrival strobe: monster=0, broken bit L=1.
- **Hit:**
  - With dist=2 on lane L, pulse hit[L]: next cycle monster=0, score=1, broken unchanged.
  - A hit on an empty lane leaves score unchanged.
- **Hit vs arrival same cycle:** hit[L] on the arrival strobe with dist=1. Required: broken[L]=0, score+1.
- **Lane probing:**
  - Force lanes L and L+1 broken. The next attempt spawns on L+2 (mod 4).
  - With all free lanes occupied, the attempt spawns nothing and the timer still reloads.
- **Game over/restart:**
  - Let all four lanes arrive: state=2, broken=4'b1111, monster=0.
  - Pulse Start: state=1, broken=0, score=0.
  - Score saturation: 260 hits leave score=255.
